// File: rtl/pipeline_md_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit:
// funct3 opcodes, FSM states and operand signedness classes.
package pipeline_md_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_DONE
    } md_state_e;

    typedef enum logic [1:0] {
        MD_CLS_UU,
        MD_CLS_SS,
        MD_CLS_SU
    } md_cls_e;

    // MUL shares the signed class so it pairs with MULH
    function automatic md_cls_e md_class(input logic [2:0] op);
        md_cls_e c;
        unique case (op)
            MD_MULHSU:                  c = MD_CLS_SU;
            MD_MULHU, MD_DIVU, MD_REMU: c = MD_CLS_UU;
            default:                    c = MD_CLS_SS;
        endcase
        return c;
    endfunction

    function automatic logic md_half(input logic [2:0] op);
        return op[2] ? op[1] : (op != MD_MUL);
    endfunction

endpackage

// File: rtl/pipeline_md_step.sv
// One radix-2 iteration: shift-add multiply or
// restoring compare-subtract-shift divide.
module pipeline_md_step #(
    parameter int XLEN = 32
) (
    input  logic            i_div,
    input  logic [XLEN-1:0] i_acc,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_acc,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shl;
    logic [XLEN-1:0] w_sub;
    logic            w_ge;

    always_comb begin
        w_sum = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_b} : '0);
        w_shl = {i_acc, i_lo[XLEN-1]};
        w_ge  = w_shl >= {1'b0, i_b};
        w_sub = w_shl[XLEN-1:0] - i_b;
        o_acc = w_sum[XLEN:1];
        o_lo  = {w_sum[0], i_lo[XLEN-1:1]};
        if (i_div) begin
            o_acc = w_ge ? w_sub : w_shl[XLEN-1:0];
            o_lo  = {i_lo[XLEN-2:0], w_ge};
        end
    end

endmodule

// File: rtl/pipeline_ex_md.sv
// Iterative RV32M/RV64M multiply/divide unit beside the EX ALU.
// `define PIPELINE_EX_MD_OPCACHE_EN reuses the last result pair.
module pipeline_ex_md
    import pipeline_md_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int STEPS_PER_CYCLE = 1,
    parameter int CNT_W           = $clog2(XLEN / STEPS_PER_CYCLE + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [2:0]      opsel_i,
    input  logic [XLEN-1:0] val1_i,
    input  logic [XLEN-1:0] val2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [4:0]      rd_o,
    output logic            we_o,
    output logic [XLEN-1:0] wdata_o
);

    localparam int              NSTEP   = XLEN / STEPS_PER_CYCLE;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        r_state;
    logic [2:0]       r_op;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_acc;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_b;
    logic             r_negq;
    logic             r_negr;
    logic [CNT_W-1:0] r_cnt;

    md_cls_e         w_cls;
    logic            w_s1;
    logic            w_s2;
    logic            w_special;
    logic            w_accept;
    logic            w_hit;
    logic            w_done;
    logic [XLEN-1:0] w_acc_n;
    logic [XLEN-1:0] w_lo_n;

    assign w_cls     = md_class(opsel_i);
    assign w_s1      = (w_cls != MD_CLS_UU) && val1_i[XLEN-1];
    assign w_s2      = (w_cls == MD_CLS_SS) && val2_i[XLEN-1];
    assign w_accept  = (r_state == MD_IDLE) && valid_i && !flush_i;
    assign w_done    = (r_state == MD_DONE);
    assign w_special = opsel_i[2] && ((val2_i == '0) ||
                       ((w_cls == MD_CLS_SS) && (val1_i == MIN_NEG) &&
                        (val2_i == '1)));

    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        logic [XLEN-1:0] w_acc_in;
        logic [XLEN-1:0] w_lo_in;
        logic [XLEN-1:0] w_acc_out;
        logic [XLEN-1:0] w_lo_out;
        if (g == 0) begin : g_first
            assign w_acc_in = r_acc;
            assign w_lo_in  = r_lo;
        end else begin : g_next
            assign w_acc_in = g_step[g-1].w_acc_out;
            assign w_lo_in  = g_step[g-1].w_lo_out;
        end
        pipeline_md_step #(.XLEN(XLEN)) u_step (
            .i_div (r_op[2]),
            .i_acc (w_acc_in),
            .i_lo  (w_lo_in),
            .i_b   (r_b),
            .o_acc (w_acc_out),
            .o_lo  (w_lo_out)
        );
    end
    assign w_acc_n = g_step[STEPS_PER_CYCLE-1].w_acc_out;
    assign w_lo_n  = g_step[STEPS_PER_CYCLE-1].w_lo_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            r_op    <= '0;
            r_rd    <= '0;
            r_acc   <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_negq  <= 1'b0;
            r_negr  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        r_op <= opsel_i;
                        r_rd <= rd_i;
                        if (w_hit) begin
                            r_state <= MD_DONE;
                        end else if (w_special) begin
                            // result pair loaded directly, no sign fix-up
                            r_lo    <= (val2_i == '0) ? '1 : val1_i;
                            r_acc   <= (val2_i == '0) ? val1_i : '0;
                            r_negq  <= 1'b0;
                            r_negr  <= 1'b0;
                            r_state <= MD_DONE;
                        end else begin
                            r_acc   <= '0;
                            r_lo    <= w_s1 ? -val1_i : val1_i;
                            r_b     <= w_s2 ? -val2_i : val2_i;
                            r_negq  <= w_s1 ^ w_s2;
                            r_negr  <= w_s1;
                            r_cnt   <= CNT_W'(NSTEP);
                            r_state <= MD_RUN;
                        end
                    end
                end
                MD_RUN: begin
                    if (flush_i) begin
                        r_state <= MD_IDLE;
                    end else begin
                        r_acc <= w_acc_n;
                        r_lo  <= w_lo_n;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) r_state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (!hold_i) r_state <= MD_IDLE;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

`ifdef PIPELINE_EX_MD_OPCACHE_EN
    logic            r_c_v;
    logic            r_c_div;
    logic            r_c_half;
    md_cls_e         r_c_cls;
    logic [XLEN-1:0] r_c_a;
    logic [XLEN-1:0] r_c_b;

    assign w_hit = r_c_v && (r_c_div == opsel_i[2]) &&
                   (r_c_cls == w_cls) && (r_c_a == val1_i) &&
                   (r_c_b == val2_i) && (r_c_half != md_half(opsel_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_v    <= 1'b0;
            r_c_div  <= 1'b0;
            r_c_half <= 1'b0;
            r_c_cls  <= MD_CLS_UU;
            r_c_a    <= '0;
            r_c_b    <= '0;
        end else if (flush_i && !(w_done && hold_i)) begin
            r_c_v <= 1'b0;
        end else if (w_accept) begin
            r_c_half <= md_half(opsel_i);
            if (!w_hit) begin
                r_c_v   <= w_special;
                r_c_div <= opsel_i[2];
                r_c_cls <= w_cls;
                r_c_a   <= val1_i;
                r_c_b   <= val2_i;
            end
        end else if ((r_state == MD_RUN) && (r_cnt == CNT_W'(1))) begin
            r_c_v <= 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res;
    logic              w_is_lo;
    logic              w_is_hi;
    logic              w_is_rem;
    logic              w_is_quo;

    assign w_prod   = r_negq ? -{r_acc, r_lo} : {r_acc, r_lo};
    assign w_quo    = r_negq ? -r_lo : r_lo;
    assign w_rem    = r_negr ? -r_acc : r_acc;
    assign w_is_lo  = (r_op == MD_MUL);
    assign w_is_hi  = !r_op[2] && (r_op != MD_MUL);
    assign w_is_rem = r_op[2] && r_op[1];
    assign w_is_quo = r_op[2] && !r_op[1];

    always_comb begin
        w_res = w_quo;
        unique case (1'b1)
            w_is_lo:  w_res = w_prod[XLEN-1:0];
            w_is_hi:  w_res = w_prod[2*XLEN-1:XLEN];
            w_is_rem: w_res = w_rem;
            w_is_quo: w_res = w_quo;
            default:  w_res = w_quo;
        endcase
    end

    assign stall_o = w_accept || (r_state != MD_IDLE);
    assign valid_o = w_done && !hold_i && !flush_i;
    assign we_o    = valid_o && (r_rd != 5'd0);
    assign rd_o    = w_done ? r_rd : 5'd0;
    assign wdata_o = w_done ? w_res : '0;

endmodule

// File: tb/tb_pipeline_ex_md.sv
// Randomized self-checking bench for pipeline_ex_md (XLEN=32)
// against an arithmetic reference model.
module tb_pipeline_ex_md;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [2:0]  opsel_i = '0;
    logic [31:0] val1_i = '0;
    logic [31:0] val2_i = '0;
    logic [4:0]  rd_i = '0;
    logic        flush_i = 1'b0;
    logic        hold_i = 1'b0;
    logic        stall_o;
    logic        valid_o;
    logic [4:0]  rd_o;
    logic        we_o;
    logic [31:0] wdata_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_ex_md dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .opsel_i (opsel_i),
        .val1_i  (val1_i),
        .val2_i  (val2_i),
        .rd_i    (rd_i),
        .flush_i (flush_i),
        .hold_i  (hold_i),
        .stall_o (stall_o),
        .valid_o (valid_o),
        .rd_o    (rd_o),
        .we_o    (we_o),
        .wdata_o (wdata_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb;
                return 32'(q);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                q = sa % sb;
                return 32'(q);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

`ifdef PIPELINE_EX_MD_OPCACHE_EN
    bit          c_v = 1'b0;
    logic [66:0] c_key;
    bit          c_half;

    function automatic logic [66:0] key_of(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        bit s1;
        bit s2;
        s1 = (op == 0 || op == 1 || op == 2 || op == 4 || op == 6);
        s2 = (op == 0 || op == 1 || op == 4 || op == 6);
        return {op[2], s1, s2, a, b};
    endfunction

    function automatic bit half_of(input logic [2:0] op);
        if (op == 0) return 1'b0;
        if (op < 4) return 1'b1;
        return op[1];
    endfunction
`endif

    function automatic int exp_lat(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && (b == 0 ||
            (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
`ifdef PIPELINE_EX_MD_OPCACHE_EN
        if (c_v && c_key == key_of(op, a, b) && c_half != half_of(op))
            return 2;
`endif
        return 32 + 2;
    endfunction

    task automatic cache_drop();
`ifdef PIPELINE_EX_MD_OPCACHE_EN
        c_v = 1'b0;
`endif
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input int hold_n);
        int          lat;
        int          k;
        bit          got;
        bit          stall_bad;
        bit          hold_bad;
        logic [31:0] er;
        er  = ref_res(op, a, b);
        lat = exp_lat(op, a, b);
        @(posedge clk); #1;
        valid_i = 1'b1; opsel_i = op; val1_i = a; val2_i = b;
        rd_i = rd; hold_i = (hold_n > 0);
        k = 0; got = 0; stall_bad = 0; hold_bad = 0;
        while (!got && k < 80) begin
            @(negedge clk);
            k++;
            if (!stall_o) stall_bad = 1;
            if (valid_o) begin
                got = 1;
            end else begin
                if (hold_n > 0 && k >= lat &&
                    (wdata_o !== er || rd_o !== rd)) hold_bad = 1;
                @(posedge clk); #1;
                valid_i = 1'b0;
                if (k >= lat + hold_n - 1) hold_i = 1'b0;
            end
        end
        chk($sformatf("done op%0d", op), 64'(got), 64'(1));
        chk($sformatf("lat op%0d", op), 64'(k), 64'(lat + hold_n));
        chk($sformatf("wdata op%0d", op), 64'(wdata_o), 64'(er));
        chk($sformatf("rd op%0d", op), 64'(rd_o), 64'(rd));
        chk($sformatf("we op%0d", op), 64'(we_o), 64'(rd != 5'd0));
        chk($sformatf("stall op%0d", op), 64'(stall_bad), 64'(0));
        if (hold_n > 0)
            chk($sformatf("hold op%0d", op), 64'(hold_bad), 64'(0));
        @(negedge clk);
        chk("post_valid", 64'(valid_o), 64'(0));
        chk("post_stall", 64'(stall_o), 64'(0));
        valid_i = 1'b0;
        hold_i  = 1'b0;
`ifdef PIPELINE_EX_MD_OPCACHE_EN
        c_v = 1'b1; c_key = key_of(op, a, b); c_half = half_of(op);
`endif
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        @(posedge clk); #1;
        valid_i = 1'b1; opsel_i = op; val1_i = a; val2_i = b; rd_i = 5'd4;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic quiet_check(input string tag);
        bit seen;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) seen = 1;
        end
        chk(tag, 64'(seen), 64'(0));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stall"}, 64'(stall_o), 64'(0));
        chk({tag, "_valid"}, 64'(valid_o), 64'(0));
        chk({tag, "_we"}, 64'(we_o), 64'(0));
        chk({tag, "_rd"}, 64'(rd_o), 64'(0));
        chk({tag, "_wdata"}, 64'(wdata_o), 64'(0));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
        run_op(3'd5, 32'd1234, 32'd0, 5'd9, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        run_op(3'd0, 32'd123, 32'd456, 5'd0, 0);
        run_op(3'd0, 32'h1234, 32'h5678, 5'd3, 3);

        // kill in RUN cycle 10
        start_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_stall", 64'(stall_o), 64'(0));
        chk("flush_valid", 64'(valid_o), 64'(0));
        quiet_check("flush_quiet");
        cache_drop();
        run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd12, 0);

        // asynchronous reset mid-RUN
        start_op(3'd7, 32'hFFFF_0000, 32'd3);
        repeat (13) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        cache_drop();
        quiet_check("rst_quiet");
        run_op(3'd4, 32'd100, 32'hFFFF_FFF9, 5'd13, 0);

        ra = pick();
        rb = pick();
        for (int i = 0; i < 30; i++) begin
            logic [2:0] op;
            logic [4:0] rd;
            if ($urandom_range(0, 3) != 0) begin
                ra = pick();
                rb = pick();
            end
            op = 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 3) == 0) ? 5'd0
                                             : 5'($urandom_range(1, 31));
            run_op(op, ra, rb, rd, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_ex_md.md
Name: pipeline_ex_md

Overview:
- Parametrised multi-cycle execute unit adding RV32M/RV64M multiply/divide to the EX stage.
- Sits beside the single-cycle ALU in EX. EX routes M-extension ops here with already-forwarded operands.
- Holds the pipeline via stall_o until the result is written into the EX/MEM fields.
- Iterative shift-add multiplier and restoring divider share one FSM and one datapath register set.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- STEPS_PER_CYCLE, 1, radix-2 iterations per clock; must divide XLEN (1, 2, 4).
- CNT_W, $clog2(XLEN/STEPS_PER_CYCLE+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- valid_i  in  1  M-op present in EX this cycle.
- opsel_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- val1_i  in  XLEN  rs1 value (forwarded).
- val2_i  in  XLEN  rs2 value (forwarded).
- rd_i  in  5  destination register.
- flush_i  in  1  branch-taken kill; aborts any op in flight.
- hold_i  in  1  downstream (MEM) stall; result must be held.
- stall_o  out  1  request upstream stall (IF/ID/EX freeze).
- valid_o  out  1  result valid to EX/MEM.
- rd_o  out  5  destination register.
- we_o  out  1  register write enable.
- wdata_o  out  XLEN  result.

Behaviour:
- Reset (rst_n low, any state, async): state=IDLE, stall_o=0, valid_o=0, we_o=0, rd_o=0, wdata_o=0, counter=0. Work registers cleared.
- States:
  - IDLE. On valid_i && !flush_i: latch opsel_i, rd_i, |val1_i|, |val2_i| (per signedness) and result sign.
    - Special divide case: go to DONE.
    - Otherwise: go to RUN, counter=XLEN/STEPS_PER_CYCLE.
  - RUN. Perform STEPS_PER_CYCLE steps per clock, counter--. At counter==1 go to DONE.
  - DONE. Apply sign correction (two's-complement negate if result sign set) and select the low/high half or quotient/remainder.
    - If !hold_i: drive valid_o=we_o=1 with rd_o/wdata_o for exactly one cycle, then return to IDLE.
    - If hold_i: stay in DONE with outputs stable.
- stall_o: combinationally high when (IDLE && valid_i && !flush_i) or state is RUN or DONE. Low in the cycle after valid_o is issued.
- Latency: special divide cases 2 cycles (accept, DONE). Others XLEN/STEPS_PER_CYCLE+2 cycles (34 at defaults).
- Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; DIV/REM signed.
  - Quotient sign = s1^s2. Remainder sign = s1.
  - Product is 2*XLEN wide. MUL returns the low half, MULH* the high half.
- Divide by zero: DIV/DIVU result all-ones; REM/REMU result = val1_i.
- Signed overflow (val1=-2^(XLEN-1), val2=-1): DIV result val1; REM result 0.
- rd_i==0: op executes normally, but we_o is forced to 0 at issue.
- flush_i in any state except DONE-with-hold: return to IDLE next cycle, no valid_o, stall_o drops.
- flush_i while in DONE with hold_i: ignored; the op is architecturally older than the branch.
- valid_i while busy: ignored. EX is stalled, so it re-presents the same op, and that op is not re-accepted until IDLE.

Optional Feature:
- Macro: PIPELINE_EX_MD_OPCACHE_EN.
- Defined: keep the last operands, signedness class and full result pair (quotient+remainder, or full 2*XLEN product).
  - A new op whose operands and class match, and which selects the other half (DIV after REM, MULH after MUL, etc.), bypasses RUN: IDLE to DONE, 2-cycle latency.
  - The cache is invalidated by reset and by flush_i.
- Undefined: every op takes full latency; no cache registers.

Decomposition:
- Package pipeline_md_pkg holds:
  - funct3 localparams MD_MUL..MD_REMU.
  - State encoding MD_IDLE/MD_RUN/MD_DONE.
  - Signedness-class encoding.
- Sub-module pipeline_md_step: combinational single radix-2 step. It does one add-shift for multiply or one compare-subtract-shift for divide, selected by a mode bit. It is instantiated STEPS_PER_CYCLE times in a chain.

Test Plan:
- MUL 7*(-3), XLEN=32 -> wdata_o=0xFFFFFFEB, valid_o one cycle, 34 cycles after accept; stall_o high throughout.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
- Special divide cases:
  - DIVU x/0 -> 0xFFFFFFFF, 2-cycle latency.
  - REM 0x80000000/-1 -> 0.
  - DIV 0x80000000/-1 -> 0x80000000.
- Flush and reset:
  - flush_i at RUN cycle 10 -> no valid_o, stall_o low next cycle, next op correct.
  - rst_n low mid-RUN -> all outputs 0 immediately.
- hold_i high 3 cycles in DONE -> outputs stable, single valid_o handoff on release. With the macro defined, DIV then REM on the same operands -> REM latency 2.
